// File: rtl/mm_seq_ctrl.sv
// Sequential 2x2 8-bit matrix multiply: one shared 8x8 MAC per clock, eight steps per job.
// Optional MM_SEQ_CTRL_SAT_EN clamps overflowing elements to 8'hFF instead of wrapping mod 256.
module mm_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

`ifdef MM_SEQ_CTRL_SAT_EN
  localparam int AW = 9;
`else
  localparam int AW = 8;
`endif

  state_t               state, state_nxt;
  logic [2:0]           step;
  logic [3:0][7:0]      a_q, b_q;
  logic [3:0][AW-1:0]   acc, acc_upd;
  logic [31:0]          res_q;
  logic [3:0][7:0]      res_nxt;

  // step = {i,j,k}; element n of a packed matrix lives at slot 3-n (= ~n for 2 bits)
  logic [1:0]  a_idx, b_idx, r_idx;
  logic [7:0]  a_op, b_op;
  logic [15:0] prod;
  logic [AW-1:0] sum;

  assign a_idx = {step[2], step[0]};
  assign b_idx = {step[0], step[1]};
  assign r_idx = step[2:1];
  assign a_op  = a_q[~a_idx];
  assign b_op  = b_q[~b_idx];
  assign prod  = {8'h00, a_op} * {8'h00, b_op};

`ifdef MM_SEQ_CTRL_SAT_EN
  logic [3:0] ovf, ovf_upd;

  assign sum = {1'b0, acc[r_idx][7:0]} + {1'b0, prod[7:0]};

  always_comb begin
    acc_upd        = acc;
    ovf_upd        = ovf;
    acc_upd[r_idx] = sum;
    ovf_upd[r_idx] = ovf[r_idx] | (|prod[15:8]) | sum[8];
    for (int n = 0; n < 4; n++)
      res_nxt[3-n] = (ovf_upd[n] | acc_upd[n][8]) ? 8'hFF : acc_upd[n][7:0];
  end
`else
  logic prod_hi_unused;
  assign prod_hi_unused = ^prod[15:8];

  assign sum = acc[r_idx] + prod[7:0];

  always_comb begin
    acc_upd        = acc;
    acc_upd[r_idx] = sum;
    for (int n = 0; n < 4; n++)
      res_nxt[3-n] = acc_upd[n];
  end
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        if (step == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign res = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= 3'd0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      res_q <= 32'h0;
`ifdef MM_SEQ_CTRL_SAT_EN
      ovf   <= 4'h0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          acc   <= '0;
          step  <= 3'd0;
`ifdef MM_SEQ_CTRL_SAT_EN
          ovf   <= 4'h0;
`endif
        end
        MAC: begin
          acc  <= acc_upd;
          step <= step + 3'd1;
`ifdef MM_SEQ_CTRL_SAT_EN
          ovf  <= ovf_upd;
`endif
          // step 7 finishes R11, so res takes the post-update accumulators
          if (step == 3'd7) res_q <= res_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl; expected results are queued at issue and checked by a monitor.
module tb_mm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mm_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, the handshake completes on the following rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", res);
      end else begin
        chk("res", res, exp_q.pop_front());
      end
    end
  end

  // Issue one job; returns after the acceptance edge (+1)
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEADBEEF; b = 32'hCAFEF00D;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic job(input string name, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] exp);
    int n;
    exp_q.push_back(exp);
    out_ready = 1'b1;
    issue(av, bv);
    wait_out(n);
    chk({name, "_latency"}, n, 8);
    @(posedge clk); #1;
    chk({name, "_out_valid_after_hs"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_in_ready_after_hs"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res", res, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    job("basic",  32'h01020304, 32'h05060708, 32'h13162B32);
    job("ident",  32'h01000001, 32'h05060708, 32'h05060708);
    job("swap",   32'h00010100, 32'h05060708, 32'h07080506);
    job("mixed",  32'h02030405, 32'h06070809, 32'h24294049);
`ifdef MM_SEQ_CTRL_SAT_EN
    job("ovf16",  32'h10101010, 32'h10101010, 32'hFFFFFFFF);
    job("ovfff",  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    job("ovf16",  32'h10101010, 32'h10101010, 32'h00000000);
    job("ovfff",  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h02020202);
`endif

    // Backpressure, with stray in_valid pulses during MAC and DONE
    exp_q.push_back(32'h13162B32);
    out_ready = 1'b0;
    issue(32'h01020304, 32'h05060708);
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid = (n == 3);
      a = 32'h11111111; b = 32'h22222222;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("bp_latency", n, 8);
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 2);
      @(posedge clk); #1;
      chk("bp_res_stable", res, 32'h13162B32);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    chk("bp_in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    chk("bp_res_held", res, 32'h13162B32);

    // Reset after the MAC step 4 edge: no output for this job
    issue(32'h05050505, 32'h07070707);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_res", res, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_output", {31'b0, out_valid}, 32'd0);
    job("after_rst", 32'h01020304, 32'h05060708, 32'h13162B32);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mm_seq_ctrl.md
# mm_seq_ctrl

Sequential controller for the 2x2 8-bit matrix-multiply datapath. It accepts packed operand matrices A and B over a valid/ready handshake. It computes Res = A x B with a single shared 8x8 multiplier and accumulator, one multiply-accumulate per clock. It returns the packed result over a second valid/ready handshake. It replaces the fully combinational 2x2 multiplier wherever area matters more than latency.

## Interface
- No parameters. Element width is fixed at 8 bits and matrix size at 2x2.
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block can accept an operand pair
- a  input  32  matrix A packed {A00,A01,A10,A11}, A00 in bits [31:24]
- b  input  32  matrix B packed {B00,B01,B10,B11}, same packing
- out_valid  output  1  res holds a completed product
- out_ready  input  1  downstream accepts res
- res  output  32  product packed {R00,R01,R10,R11}, same packing
- busy  output  1  high whenever the state is not IDLE

## Operation
- States and transitions:
  - IDLE: in_ready=1. When in_valid=1, latch a and b into internal registers, clear all four accumulators, set step=0, go to MAC.
  - MAC: in_ready=0. Each cycle performs one step, step[2:0]={i,j,k}: acc[i][j] <= acc[i][j] + A[i][k]*B[k][j]. The step order is therefore R00 k0, R00 k1, R01 k0, R01 k1, R10 k0, R10 k1, R11 k0, R11 k1. After step 7, load res from the final accumulators, set out_valid=1 and go to DONE.
  - DONE: out_valid=1 and res is held stable. When out_ready=1, clear out_valid and go to IDLE.
- in_valid is ignored outside IDLE. Latched operands do not follow later changes on a/b.
- Arithmetic:
  - Each product is a full 16-bit value.
  - The accumulator sum is truncated to 8 bits, so each element is mod 256. This matches the combinational datapath bit-for-bit.
- res keeps its last value after the handshake. It changes only when a new computation completes.
- Reset may be asserted in any state, including mid-MAC. It forces IDLE immediately, aborts any partial computation, and produces no output.
- Reset values:
  - state=IDLE, step=0, accumulators=0, res=32'h0
  - out_valid=0, busy=0, in_ready=1

## Timing
- Input handshake completes on edge E0 (in_valid and in_ready both high).
- MAC steps 0..7 execute on edges E1..E8.
- out_valid rises after E8, giving a latency of 8 cycles from acceptance to out_valid.
- Output handshake completes on the first edge with out_valid=1 and out_ready=1. State returns to IDLE after that edge.
- in_ready reasserts one cycle after the output handshake. There is no overlap between jobs.
- Minimum period is 10 cycles per job: 1 IDLE accept + 8 MAC + 1 DONE.
- in_ready and busy are decoded directly from the state register. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- Macro: MM_SEQ_CTRL_SAT_EN.
- Defined:
  - Each accumulator is 9 bits wide with a sticky overflow flag.
  - If any product exceeds 255, or any running sum exceeds 255, the element saturates to 8'hFF.
  - res carries the clamped values.
- Undefined: mod-256 wrap as described in Operation. The saturation logic is not synthesized.
- Handshake timing and latency are identical in both builds.

## Test plan
- Basic product: a={1,2,3,4}, b={5,6,7,8} -> out_valid exactly 8 cycles after acceptance; res=32'h13162B32 (19,22,43,50).
- Identity: a={1,0,0,1}, b={5,6,7,8} -> res=32'h05060708. Then a second job with a={0,1,1,0} and the same b -> res=32'h07080506.
- Overflow: a=b={16,16,16,16}:
  - without MM_SEQ_CTRL_SAT_EN -> res=32'h00000000;
  - with MM_SEQ_CTRL_SAT_EN -> res=32'hFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> res stable at 32'h13162B32, out_valid=1, in_ready=0 throughout. An in_valid pulse with new a/b during MAC or DONE is ignored. After out_ready=1 for one edge -> out_valid=0, and in_ready=1 one cycle later.
- Reset mid-operation: assert rst after the MAC step 4 edge -> out_valid=0, res=0, busy=0 and in_ready=1 immediately. Accept a new job after deassertion -> correct result with no stale accumulator contribution.
